// File: rtl/lsu_ram_ctrl.sv
// LSU-to-SRAM controller: byte/half/word loads and stores over a
// single-port tri-state RAM, sub-word stores via read-modify-write.
module lsu_ram_ctrl #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  req_valid_i,
  output logic                  req_ready_o,
  input  logic                  req_we_i,
  input  logic [1:0]            req_size_i,
  input  logic                  req_unsigned_i,
  input  logic [ADDR_WIDTH+1:0] req_addr_i,
  input  logic [DATA_WIDTH-1:0] req_wdata_i,
  output logic                  rsp_valid_o,
  output logic [DATA_WIDTH-1:0] rsp_rdata_o,
  output logic                  rsp_err_o,
  output logic                  mem_cs_o,
  output logic                  mem_we_o,
  output logic                  mem_oe_o,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  inout  wire  [DATA_WIDTH-1:0] mem_data_io
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_CAPTURE,
    S_MERGE,
    S_RESP
  } state_t;

  state_t                r_state;
  state_t                w_next;
  logic                  r_we;
  logic [1:0]            r_size;
  logic                  r_unsigned;
  logic [ADDR_WIDTH+1:0] r_addr;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic [DATA_WIDTH-1:0] r_word;
  logic [DATA_WIDTH-1:0] r_rdata;
  logic                  r_err;

  logic                  w_req_err;
  logic                  w_word_st;
  logic [7:0]            w_byte;
  logic [15:0]           w_half;
  logic [DATA_WIDTH-1:0] w_load;
  logic [DATA_WIDTH-1:0] w_merge;
  logic [DATA_WIDTH-1:0] w_wdata;

  assign w_req_err =
    (req_size_i == 2'b11) |
    ((req_size_i == 2'b01) & req_addr_i[0]) |
    ((req_size_i == 2'b10) & (|req_addr_i[1:0]));

  assign w_word_st = r_we & (r_size == 2'b10);

  always_comb begin
    w_next      = r_state;
    req_ready_o = 1'b0;
    rsp_valid_o = 1'b0;
    mem_cs_o    = 1'b0;
    mem_we_o    = 1'b0;
    mem_oe_o    = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        req_ready_o = 1'b1;
        if (req_valid_i)
          w_next = w_req_err ? S_RESP : S_ISSUE;
      end
      S_ISSUE: begin
        mem_cs_o = 1'b1;
        if (w_word_st) begin
          mem_we_o = 1'b1;
          w_next   = S_RESP;
        end else begin
          mem_oe_o = 1'b1;
          w_next   = S_CAPTURE;
        end
      end
      S_CAPTURE: begin
        mem_cs_o = 1'b1;
        mem_oe_o = 1'b1;
        w_next   = r_we ? S_MERGE : S_RESP;
      end
      S_MERGE: begin
        mem_cs_o = 1'b1;
        mem_we_o = 1'b1;
        w_next   = S_RESP;
      end
      S_RESP: begin
        rsp_valid_o = 1'b1;
        w_next      = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    unique case (r_addr[1:0])
      2'd0:    w_byte = mem_data_io[7:0];
      2'd1:    w_byte = mem_data_io[15:8];
      2'd2:    w_byte = mem_data_io[23:16];
      default: w_byte = mem_data_io[31:24];
    endcase
    w_half = r_addr[1] ? mem_data_io[31:16] : mem_data_io[15:0];
    unique case (r_size)
      2'b00:
        w_load = {{24{~r_unsigned & w_byte[7]}}, w_byte};
      2'b01:
        w_load = {{16{~r_unsigned & w_half[15]}}, w_half};
      default:
        w_load = mem_data_io;
    endcase
  end

  always_comb begin
    w_merge = r_word;
    if (r_size == 2'b00) begin
      unique case (r_addr[1:0])
        2'd0:    w_merge[7:0]   = r_wdata[7:0];
        2'd1:    w_merge[15:8]  = r_wdata[7:0];
        2'd2:    w_merge[23:16] = r_wdata[7:0];
        default: w_merge[31:24] = r_wdata[7:0];
      endcase
    end else if (r_addr[1]) begin
      w_merge[31:16] = r_wdata[15:0];
    end else begin
      w_merge[15:0] = r_wdata[15:0];
    end
  end

  assign w_wdata     = (r_state == S_MERGE) ? w_merge : r_wdata;
  assign mem_data_io = mem_we_o ? w_wdata : {DATA_WIDTH{1'bz}};
  assign mem_addr_o  = r_addr[ADDR_WIDTH+1:2];
  assign rsp_rdata_o = r_rdata;
  assign rsp_err_o   = r_err;

  // Response registers change only on the edge entering RESP
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state    <= S_IDLE;
      r_we       <= 1'b0;
      r_size     <= 2'b00;
      r_unsigned <= 1'b0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_word     <= '0;
      r_rdata    <= '0;
      r_err      <= 1'b0;
    end else begin
      r_state <= w_next;
      unique case (r_state)
        S_IDLE: begin
          if (req_valid_i) begin
            r_we       <= req_we_i;
            r_size     <= req_size_i;
            r_unsigned <= req_unsigned_i;
            r_addr     <= req_addr_i;
            r_wdata    <= req_wdata_i;
            if (w_req_err) begin
              r_rdata <= '0;
              r_err   <= 1'b1;
            end
          end
        end
        S_ISSUE: begin
          if (w_word_st) begin
            r_rdata <= '0;
            r_err   <= 1'b0;
          end
        end
        S_CAPTURE: begin
          r_word <= mem_data_io;
          if (!r_we) begin
            r_rdata <= w_load;
            r_err   <= 1'b0;
          end
        end
        S_MERGE: begin
          r_rdata <= '0;
          r_err   <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_ram_ctrl.sv
// Scoreboard bench for lsu_ram_ctrl: driver queues expected
// responses, a negedge monitor pops and compares them.
module tb_lsu_ram_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [1:0]  req_size = 2'b00;
  logic        req_uns = 1'b0;
  logic [9:0]  req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        mem_cs;
  logic        mem_we;
  logic        mem_oe;
  logic [7:0]  mem_addr;
  wire  [31:0] mem_data;

  logic [31:0] ram [0:255];
  logic        pl_we = 1'b0;
  logic [7:0]  pl_addr = '0;
  logic [31:0] pl_data = '0;

  typedef struct {
    logic [31:0] rd;
    logic        err;
    int          lat;
    int          acc;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   n_chk = 0;
  int   n_pass = 0;
  int   n_both = 0;
  int   n_cs_err = 0;
  bit   err_win = 0;

  lsu_ram_ctrl #(.DATA_WIDTH(32), .ADDR_WIDTH(8)) dut (
    .clk_i          (clk),
    .rst_ni         (rst_n),
    .req_valid_i    (req_valid),
    .req_ready_o    (req_ready),
    .req_we_i       (req_we),
    .req_size_i     (req_size),
    .req_unsigned_i (req_uns),
    .req_addr_i     (req_addr),
    .req_wdata_i    (req_wdata),
    .rsp_valid_o    (rsp_valid),
    .rsp_rdata_o    (rsp_rdata),
    .rsp_err_o      (rsp_err),
    .mem_cs_o       (mem_cs),
    .mem_we_o       (mem_we),
    .mem_oe_o       (mem_oe),
    .mem_addr_o     (mem_addr),
    .mem_data_io    (mem_data)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Asynchronous-read, synchronous-write RAM with a preload port
  assign mem_data = (mem_cs && mem_oe && !mem_we) ?
                    ram[mem_addr] : 32'bz;

  always @(posedge clk) begin
    if (pl_we)
      ram[pl_addr] <= pl_data;
    else if (mem_cs && mem_we)
      ram[mem_addr] <= mem_data;
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h want %h", nm, act, exp);
  endtask

  always @(negedge clk) begin
    if (mem_we && mem_oe) n_both++;
    if (err_win && mem_cs) n_cs_err++;
  end

  always @(negedge clk) begin
    if (rst_n && rsp_valid) begin
      if (sb.size() == 0) begin
        chk("unexpected_rsp", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("rdata", rsp_rdata, e.rd);
        chk("err", {31'd0, rsp_err}, {31'd0, e.err});
        chk("latency", cyc - e.acc + 1, e.lat);
        chk("ready_in_resp", {31'd0, req_ready}, 32'd0);
      end
    end
  end

  task automatic preload(input logic [7:0] a, input logic [31:0] d);
    pl_addr = a;
    pl_data = d;
    pl_we   = 1'b1;
    @(negedge clk);
    pl_we   = 1'b0;
  endtask

  task automatic issue(input logic we, input logic [1:0] sz,
                       input logic uns, input logic [9:0] a,
                       input logic [31:0] wd, input logic [31:0] er,
                       input logic ee, input int el, input bit hold);
    int k;
    exp_t e;
    req_we    = we;
    req_size  = sz;
    req_uns   = uns;
    req_addr  = a;
    req_wdata = wd;
    req_valid = 1'b1;
    k = 0;
    while (!req_ready && k < 30) begin
      @(negedge clk);
      k++;
    end
    if (!req_ready) begin
      chk("accept_timeout", 32'd1, 32'd0);
      req_valid = 1'b0;
      return;
    end
    e.rd  = er;
    e.err = ee;
    e.lat = el;
    e.acc = cyc + 1;
    sb.push_back(e);
    @(negedge clk);
    chk("busy_ready", {31'd0, req_ready}, 32'd0);
    if (!hold) req_valid = 1'b0;
  endtask

  task automatic drain();
    int k;
    k = 0;
    while (sb.size() != 0 && k < 50) begin
      @(negedge clk);
      k++;
    end
    chk("drain", sb.size(), 32'd0);
  endtask

  task automatic chk_reset_vals(input string nm);
    chk({nm, "_ready"}, {31'd0, req_ready}, 32'd1);
    chk({nm, "_valid"}, {31'd0, rsp_valid}, 32'd0);
    chk({nm, "_rdata"}, rsp_rdata, 32'd0);
    chk({nm, "_err"}, {31'd0, rsp_err}, 32'd0);
    chk({nm, "_ctl"}, {29'd0, mem_cs, mem_we, mem_oe}, 32'd0);
    chk({nm, "_addr"}, {24'd0, mem_addr}, 32'd0);
  endtask

  initial begin
    int k;
    repeat (3) @(negedge clk);
    chk_reset_vals("rst0");
    preload(8'd3, 32'h8899AABB);
    preload(8'd8, 32'h11223344);
    rst_n = 1'b1;

    // Loads from word 3
    issue(0, 2'b00, 0, 10'h00E, 0, 32'hFFFFFF99, 0, 3, 0);
    issue(0, 2'b01, 1, 10'h00E, 0, 32'h00008899, 0, 3, 0);
    issue(0, 2'b01, 0, 10'h00C, 0, 32'hFFFFAABB, 0, 3, 0);
    issue(0, 2'b00, 1, 10'h00D, 0, 32'h000000AA, 0, 3, 0);
    drain();

    // Word store, byte merge, half merge
    issue(1, 2'b10, 0, 10'h010, 32'hDEADBEEF, 0, 0, 2, 0);
    issue(1, 2'b00, 0, 10'h011, 32'h00000055, 0, 0, 4, 0);
    issue(0, 2'b10, 0, 10'h010, 0, 32'hDEAD55EF, 0, 3, 0);
    issue(1, 2'b01, 0, 10'h012, 32'hCAFE1234, 0, 0, 4, 0);
    issue(0, 2'b10, 0, 10'h010, 0, 32'h123455EF, 0, 3, 0);
    drain();
    repeat (3) @(negedge clk);
    chk("rdata_hold", rsp_rdata, 32'h123455EF);

    // Errors never touch the RAM
    err_win = 1;
    issue(0, 2'b10, 0, 10'h012, 0, 32'h0, 1, 1, 0);
    issue(1, 2'b11, 0, 10'h010, 32'hFFFFFFFF, 32'h0, 1, 1, 0);
    issue(0, 2'b01, 0, 10'h011, 0, 32'h0, 1, 1, 0);
    drain();
    err_win = 0;
    chk("err_no_cs", n_cs_err, 32'd0);
    repeat (2) @(negedge clk);
    chk("err_rdata_hold", rsp_rdata, 32'h0);
    issue(0, 2'b10, 0, 10'h010, 0, 32'h123455EF, 0, 3, 0);
    drain();

    // Reset during MERGE of a byte store
    issue(1, 2'b00, 0, 10'h020, 32'h000000EE, 0, 0, 4, 0);
    k = 0;
    while (!mem_we && k < 10) begin
      @(negedge clk);
      k++;
    end
    chk("reached_merge", {31'd0, mem_we}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk_reset_vals("rst_merge");
    void'(sb.pop_back());
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    issue(0, 2'b10, 0, 10'h020, 0, 32'h11223344, 0, 3, 0);
    drain();

    // Back-to-back loads with valid held high
    issue(0, 2'b10, 0, 10'h00C, 0, 32'h8899AABB, 0, 3, 1);
    issue(0, 2'b00, 1, 10'h00F, 0, 32'h00000088, 0, 3, 1);
    issue(0, 2'b01, 0, 10'h012, 0, 32'h00001234, 0, 3, 1);
    issue(0, 2'b10, 0, 10'h010, 0, 32'h123455EF, 0, 3, 0);
    drain();

    chk("we_oe_overlap", n_both, 32'd0);
    repeat (2) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
